// File: rtl/hermes_packet_tx.sv
// Hermes NoC packet transmitter.
// Serialises a packet request into header, size and payload flits towards a
// router input port, using the router's credit signal for flow control.
module hermes_packet_tx #(
   parameter int unsigned FLIT_WIDTH = 16,
   parameter int unsigned SIZE_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [FLIT_WIDTH-1:0] req_target,
   input  logic [SIZE_WIDTH-1:0] req_size,
   input  logic                  pl_valid,
   output logic                  pl_ready,
   input  logic [FLIT_WIDTH-1:0] pl_data,
   output logic                  tx_avail,
   output logic [FLIT_WIDTH-1:0] tx_data,
   input  logic                  tx_credit,
   output logic                  busy,
   output logic                  pkt_done
);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      SIZE,
      PAYLOAD
   } state_t;

   state_t                state;
   logic [FLIT_WIDTH-1:0] target_q;
   logic [SIZE_WIDTH-1:0] size_q;
   logic [SIZE_WIDTH-1:0] load_cnt;
   logic                  tx_xfer;
   logic                  pl_fire;

   // Handshake decode; pl_ready looks at tx_credit so the output register
   // can be refilled on the same edge its current flit leaves.
   always_comb begin
      req_ready = (state == IDLE);
      tx_xfer   = tx_avail && tx_credit;
      pl_ready  = (state == PAYLOAD) && (load_cnt < size_q) && (!tx_avail || tx_credit);
      pl_fire   = pl_valid && pl_ready;
   end

   // Packet sequencer with registered flit output and status flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         target_q <= '0;
         size_q   <= '0;
         load_cnt <= '0;
         tx_avail <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  target_q <= req_target;
                  size_q   <= req_size;
                  tx_data  <= req_target;
                  tx_avail <= 1'b1;
                  busy     <= 1'b1;
                  state    <= HEADER;
               end
            end
            HEADER: begin
               if (tx_credit) begin
                  tx_data <= FLIT_WIDTH'(size_q);
                  state   <= SIZE;
               end else begin
                  tx_data <= target_q;
               end
            end
            SIZE: begin
               if (tx_credit) begin
                  tx_avail <= 1'b0;
                  load_cnt <= '0;
                  if (size_q == '0) begin
                     busy     <= 1'b0;
                     pkt_done <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               // The last flit can never coincide with a load: once
               // load_cnt reaches size_q, pl_ready is held low.
               if (pl_fire) begin
                  tx_data  <= pl_data;
                  tx_avail <= 1'b1;
                  load_cnt <= load_cnt + SIZE_WIDTH'(1);
               end else if (tx_xfer) begin
                  tx_avail <= 1'b0;
                  if (load_cnt == size_q) begin
                     busy     <= 1'b0;
                     pkt_done <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               tx_avail <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hermes_packet_tx.sv
// Self-checking bench for hermes_packet_tx: scoreboard of expected flits,
// queued when each packet request is issued and consumed as flits transfer.
module tb_hermes_packet_tx;

   localparam int unsigned FW = 16;
   localparam int unsigned SW = 8;

   logic          clock;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [FW-1:0] req_target;
   logic [SW-1:0] req_size;
   logic          pl_valid;
   logic          pl_ready;
   logic [FW-1:0] pl_data;
   logic          tx_avail;
   logic [FW-1:0] tx_data;
   logic          tx_credit;
   logic          busy;
   logic          pkt_done;

   hermes_packet_tx #(
      .FLIT_WIDTH(FW),
      .SIZE_WIDTH(SW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_target(req_target),
      .req_size  (req_size),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .pl_data   (pl_data),
      .tx_avail  (tx_avail),
      .tx_data   (tx_data),
      .tx_credit (tx_credit),
      .busy      (busy),
      .pkt_done  (pkt_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [FW-1:0] flit;
      logic          last;
   } exp_t;

   typedef struct packed {
      logic [FW-1:0] tgt;
      logic [SW-1:0] size;
   } req_t;

   exp_t          exp_q[$];
   req_t          req_q[$];
   logic [FW-1:0] src_q[$];

   int   vectors     = 0;
   int   miscompares = 0;
   logic done_pending = 1'b0;
   logic toggle       = 1'b0;
   logic force_pl     = 1'b0;
   int   credit_mode  = 0;
   int   valid_mode   = 0;
   int   pl_hs_cnt, pl_rdy_cnt, bubble_cnt, done_cnt, req_hs_cnt;
   int   stall_left, stall_arm, stall_ok;
   logic [FW-1:0] stall_hdr;

   task automatic clear_stats();
      pl_hs_cnt  = 0;
      pl_rdy_cnt = 0;
      bubble_cnt = 0;
      done_cnt   = 0;
      req_hs_cnt = 0;
      stall_left = 0;
      stall_arm  = 0;
      stall_ok   = 0;
   endtask

   task automatic queue_packet(input logic [FW-1:0] tgt, input int size, input logic [FW-1:0] base);
      req_t r;
      exp_t e;
      r.tgt  = tgt;
      r.size = SW'(size);
      req_q.push_back(r);
      e.flit = tgt;
      e.last = 1'b0;
      exp_q.push_back(e);
      e.flit = FW'(size);
      e.last = (size == 0);
      exp_q.push_back(e);
      for (int i = 0; i < size; i++) begin
         e.flit = base + FW'(i);
         e.last = (i == size - 1);
         exp_q.push_back(e);
         src_q.push_back(e.flit);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later.
   task automatic step();
      logic xfer, last_now, hs_pl, hs_req;
      req_valid = (req_q.size() != 0);
      if (req_valid) begin
         req_target = req_q[0].tgt;
         req_size   = req_q[0].size;
      end
      toggle   = ~toggle;
      pl_valid = force_pl || ((src_q.size() != 0) && (valid_mode == 0 || toggle));
      pl_data  = (src_q.size() != 0) ? src_q[0] : 16'hDEAD;
      if (stall_left > 0)
         tx_credit = 1'b0;
      else if (credit_mode == 1)
         tx_credit = 1'($urandom_range(0, 1));
      else
         tx_credit = 1'b1;
      #1;
      vectors++;
      if (pkt_done !== done_pending) begin
         miscompares++;
         $display("FAIL pkt_done: got %b want %b at %0t", pkt_done, done_pending, $time);
      end
      if (done_pending) begin
         vectors++;
         if (tx_avail !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap: tx_avail=%b busy=%b want 0/0 at %0t", tx_avail, busy, $time);
         end
      end
      if (tx_avail === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_flit: got %h want none at %0t", tx_data, $time);
         end else if (tx_data !== exp_q[0].flit) begin
            miscompares++;
            $display("FAIL tx_data: got %h want %h at %0t", tx_data, exp_q[0].flit, $time);
         end
      end
      xfer     = (tx_avail === 1'b1) && tx_credit;
      last_now = 1'b0;
      if (xfer && exp_q.size() != 0) begin
         last_now = exp_q[0].last;
         void'(exp_q.pop_front());
      end
      hs_pl  = pl_valid && (pl_ready === 1'b1);
      hs_req = req_valid && (req_ready === 1'b1);
      if (pl_ready === 1'b1) pl_rdy_cnt++;
      if (tx_avail === 1'b0 && exp_q.size() != 0 && req_q.size() == 0) bubble_cnt++;
      if (stall_left > 0) begin
         if (tx_avail === 1'b1 && tx_data === stall_hdr) stall_ok++;
         stall_left--;
      end
      @(posedge clock);
      if (hs_pl) begin
         pl_hs_cnt++;
         if (src_q.size() != 0) void'(src_q.pop_front());
      end
      if (hs_req) begin
         void'(req_q.pop_front());
         req_hs_cnt++;
         if (stall_arm > 0) begin
            stall_left = stall_arm;
            stall_arm  = 0;
         end
      end
      done_pending = last_now;
      done_cnt    += int'(last_now);
      @(negedge clock);
   endtask

   task automatic drain(input int budget, output int steps);
      steps = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0 || done_pending) && steps < budget) begin
         step();
         steps++;
      end
      vectors++;
      if (exp_q.size() != 0 || req_q.size() != 0 || done_pending) begin
         miscompares++;
         $display("FAIL timeout: %0d flits left want 0", exp_q.size());
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      vectors++;
      if (tx_avail !== 1'b0 || busy !== 1'b0 || pkt_done !== 1'b0 ||
          req_ready !== 1'b1 || pl_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: avail=%b busy=%b done=%b req_ready=%b pl_ready=%b want 0 0 0 1 0",
                  name, tx_avail, busy, pkt_done, req_ready, pl_ready);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_target = '0;
      req_size   = '0;
      pl_valid   = 1'b0;
      pl_data    = '0;
      tx_credit  = 1'b1;
      @(negedge clock);
      #1;
      check_idle_outputs("reset_flags");
      vectors++;
      if (tx_data !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_data: got %h want 0000", tx_data);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int n;
      clear_stats();
      credit_mode = 0;
      valid_mode  = 0;
      queue_packet(16'h0011, 3, 16'h00A1);
      drain(50, n);
      check_int("basic_steps", n, 8);
      check_int("basic_pl_hs", pl_hs_cnt, 3);
      check_int("basic_done", done_cnt, 1);
      check_int("basic_bubbles", bubble_cnt, 1);
   endtask

   task automatic test_size_zero();
      int n;
      clear_stats();
      force_pl = 1'b1;
      queue_packet(16'h0102, 0, 16'h0000);
      drain(30, n);
      step();
      step();
      force_pl = 1'b0;
      check_int("zero_steps", n, 4);
      check_int("zero_pl_ready", pl_rdy_cnt, 0);
      check_int("zero_pl_hs", pl_hs_cnt, 0);
      check_int("zero_done", done_cnt, 1);
   endtask

   task automatic test_stall();
      int n;
      clear_stats();
      stall_arm = 5;
      stall_hdr = 16'h0200;
      queue_packet(16'h0200, 4, 16'h00B0);
      drain(80, n);
      check_int("stall_held", stall_ok, 5);
      check_int("stall_pl_hs", pl_hs_cnt, 4);
      check_int("stall_done", done_cnt, 1);
   endtask

   task automatic test_toggle();
      int n;
      clear_stats();
      valid_mode  = 1;
      credit_mode = 1;
      queue_packet(16'h0300, 4, 16'h00C0);
      drain(300, n);
      valid_mode  = 0;
      credit_mode = 0;
      check_int("toggle_pl_hs", pl_hs_cnt, 4);
      check_int("toggle_done", done_cnt, 1);
   endtask

   task automatic test_back_to_back();
      int n;
      clear_stats();
      queue_packet(16'h0401, 2, 16'h00D0);
      queue_packet(16'h0402, 1, 16'h00E0);
      drain(80, n);
      check_int("b2b_steps", n, 12);
      check_int("b2b_done", done_cnt, 2);
      check_int("b2b_pl_hs", pl_hs_cnt, 3);
   endtask

   task automatic test_max_size();
      int n;
      clear_stats();
      queue_packet(16'h0500, 255, 16'h1000);
      drain(400, n);
      check_int("max_steps", n, 260);
      check_int("max_pl_hs", pl_hs_cnt, 255);
      check_int("max_done", done_cnt, 1);
   endtask

   task automatic test_reset_mid();
      int n;
      clear_stats();
      queue_packet(16'h0600, 5, 16'h00F0);
      n = 0;
      while (exp_q.size() > 3 && n < 50) begin
         step();
         n++;
      end
      check_int("mid_progress", exp_q.size(), 3);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outputs("mid_reset_flags");
      exp_q.delete();
      src_q.delete();
      req_q.delete();
      done_pending = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      clear_stats();
      queue_packet(16'h0700, 1, 16'h0077);
      drain(40, n);
      check_int("mid_new_steps", n, 6);
      check_int("mid_new_pl_hs", pl_hs_cnt, 1);
      check_int("mid_new_done", done_cnt, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_size_zero();
      test_stall();
      test_toggle();
      test_back_to_back();
      test_max_size();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hermes_packet_tx.md
HERMES_PACKET_TX -- requirements
Module: hermes_packet_tx

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 16, meaning the width of every flit and of the data buses.
REQ-002 The block SHALL have parameter SIZE_WIDTH, default 16, meaning the width of the payload-length field and internal counters (SIZE_WIDTH <= FLIT_WIDTH).
REQ-003 clock  input  1  single clock; all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  packet request present.
REQ-006 req_ready  output  1  request accepted on edge where req_valid && req_ready.
REQ-007 req_target  input  FLIT_WIDTH  header flit (target router address).
REQ-008 req_size  input  SIZE_WIDTH  payload flit count, 0 legal.
REQ-009 pl_valid  input  1  payload flit present.
REQ-010 pl_ready  output  1  payload flit consumed on edge where pl_valid && pl_ready.
REQ-011 pl_data  input  FLIT_WIDTH  payload flit.
REQ-012 tx_avail  output  1  flit on tx_data valid; drives router input-port rx.
REQ-013 tx_data  output  FLIT_WIDTH  flit to router input-port data_in.
REQ-014 tx_credit  input  1  router credit_o; flit transferred on edge where tx_avail && tx_credit.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 pkt_done  output  1  one-cycle pulse after last flit of a packet transferred.

Function
REQ-017 The block SHALL implement states IDLE, HEADER, SIZE, PAYLOAD; tx_avail, tx_data, busy, pkt_done SHALL be registered.
REQ-018 req_ready SHALL equal (state == IDLE); on acceptance req_target and req_size are latched, state -> HEADER, tx_data <= req_target, tx_avail <= 1 (header visible the cycle after acceptance).
REQ-019 While tx_avail=1 and tx_credit=0, tx_avail and tx_data SHALL hold unchanged (no flit dropped or replaced).
REQ-020 HEADER: on header transfer, tx_data <= zero-extended latched size, state -> SIZE, tx_avail stays 1.
REQ-021 SIZE: on size transfer, if size == 0 -> IDLE with tx_avail <= 0 and pkt_done <= 1; else -> PAYLOAD with tx_avail <= 0 and load counter cleared.
REQ-022 PAYLOAD: pl_ready SHALL be (load_cnt < size) && (!tx_avail || tx_credit) (combinational on tx_credit); on pl handshake tx_data <= pl_data, tx_avail <= 1, load_cnt += 1.
REQ-023 PAYLOAD: if the output flit transfers and no new payload is loaded that edge, tx_avail <= 0 (bubble); sustained throughput SHALL be one flit per cycle when pl_valid and tx_credit stay high.
REQ-024 When the flit with index size-1 transfers, state -> IDLE, tx_avail <= 0, pkt_done <= 1 for exactly one cycle.
REQ-025 Consecutive packets SHALL be separated by at least one cycle with tx_avail=0 (IDLE cycle for request acceptance).
REQ-026 Counters SHALL be SIZE_WIDTH bits and never wrap; size = 2^SIZE_WIDTH-1 SHALL transmit exactly that many payload flits.
REQ-027 pl_ready SHALL be 0 outside PAYLOAD; payload offered outside PAYLOAD SHALL not be consumed.
REQ-028 Flit order on tx_data SHALL be header, size, payload[0..size-1], with no duplication or reordering.

Reset
REQ-029 On reset low, immediately and asynchronously: state=IDLE, tx_avail=0, tx_data=0, busy=0, pkt_done=0, counters=0; latched target/size cleared.
REQ-030 Reset mid-packet SHALL abandon the packet; after release the block SHALL accept a new request on the first clock edge with req_valid=1, and no flits of the old packet SHALL be re-sent.

Verification
REQ-031 target=0x0011, size=3, payload 0xA1,0xA2,0xA3, credit always 1 -> tx flits 0x0011,0x0003,0xA1,0xA2,0xA3; pkt_done pulses once, one cycle after 0xA3 transfer.
REQ-032 size=0, target=0x0102 -> flits 0x0102,0x0000 only; pl_ready never asserted; pkt_done after size flit.
REQ-033 size=4, credit low for 5 cycles while header presented -> tx_data held at header, tx_avail=1 throughout; full packet then delivered intact.
REQ-034 size=4, pl_valid toggled 1,0,1,0 with random credit -> tx_avail bubbles, flit sequence intact, exactly 4 pl handshakes.
REQ-035 Two back-to-back requests (sizes 2 and 1) -> second header appears after one tx_avail=0 cycle; two pkt_done pulses.
REQ-036 reset asserted after second payload flit of size=5 packet -> tx_avail=0 same cycle; new size=1 packet after release transmits header, 0x0001, one payload.
